hazard_fwd_ctrl: RTL and testbench
==================================

# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the 5-stage CPU. It tracks destination-register info for the ID/EX, EX/MEM and MEM/WB stages in its own shadow registers. It drives the 2-bit selects of the two EX-stage operand 3-to-1 muxes, detects load-use hazards and stalls for one cycle, and squashes wrong-path instructions on a taken branch.

## Interface
- `REG_AW`, default 5: register-address width.
- `CNT_W`, default 16: statistics counter width, used only with `HFC_STATS_EN`.
- `clk_i`, in, 1: clock, rising edge.
- `rst_i`, in, 1: asynchronous active-low reset.
- `id_valid_i`, in, 1: the instruction in ID is valid.
- `id_rs_i`, `id_rt_i`, in, REG_AW: source registers of the ID instruction.
- `id_rd_i`, in, REG_AW: final destination register of the ID instruction, already muxed rt/rd.
- `id_regwrite_i`, in, 1: the ID instruction writes the register file.
- `id_memread_i`, in, 1: the ID instruction is a load.
- `ex_branch_taken_i`, in, 1: the branch in EX is resolved as taken.
- `fwd_a_sel_o`, `fwd_b_sel_o`, out, 2: operand mux selects for the EX instruction.
  - 00 = register-file data.
  - 01 = MEM/WB write-back data.
  - 10 = EX/MEM ALU result.
- `pc_write_o`, out, 1: PC enable.
- `ifid_write_o`, out, 1: IF/ID register enable.
- `idex_bubble_o`, out, 1: zero the control fields entering ID/EX.
- `ifid_flush_o`, out, 1: zero IF/ID.
- `stall_cnt_o`, `fwd_cnt_o`, out, CNT_W: statistics counters, present only with `HFC_STATS_EN`.

## Operation
- Shadow pipeline of three entries: `ex`, `mem`, `wb`. Each entry holds {valid, rd, regwrite, memread}. The `ex` entry also holds rs and rt.
- Every cycle: `wb`<=`mem`, then `mem`<=`ex`.
- `ex` is loaded from the ID inputs.
- `ex` is loaded as invalid (bubble) when any of these hold: stall, `ex_branch_taken_i`, or `id_valid_i`=0.
- Load-use stall condition, evaluated combinationally, all of:
  - `ex`.valid and `ex`.memread.
  - `ex`.rd != 0.
  - `ex`.rd == `id_rs_i` or `ex`.rd == `id_rt_i`.
  - `id_valid_i`=1.
- During a stall:
  - `pc_write_o`=0, `ifid_write_o`=0, `idex_bubble_o`=1.
  - Exactly one stall cycle per hazard. After the bubble, the load sits in `mem` and the consumer receives MEM/WB forwarding.
- Taken branch:
  - `ifid_flush_o`=1 and `idex_bubble_o`=1 in the same cycle.
  - Branch overrides stall: `pc_write_o`=1 and `ifid_write_o`=1 so the target is fetched.
- Forward selects are registered. They are computed when `ex` is loaded, using the incoming rs/rt compared against the entries that will occupy `mem` (current `ex`) and `wb` (current `mem`) next cycle:
  - 10 if that entry is valid, has regwrite, is not a load, rd != 0 and rd == source.
  - Otherwise 01 if the `wb`-bound entry is valid, has regwrite, rd != 0 and rd == source.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB. Register 0 never forwards.
- A bubble loads selects 00.
- Value 11 is never driven.

## Timing
- Reset (asynchronous on `rst_i`=0): all shadow entries invalid, selects 00, counters 0.
- Outputs during reset: `pc_write_o`=1, `ifid_write_o`=1, `idex_bubble_o`=0, `ifid_flush_o`=0.
- Reset asserted mid-stall clears the stall immediately.
- Stall and flush outputs are combinational from the ID inputs and the `ex` entry, valid in the same cycle.
- Selects change only at the clock edge and are stable for the whole EX cycle. Forwarding decision latency is one cycle (ID to EX).
- Back-to-back loads feeding each other: each load-use pair costs one stall. No other hazard stalls.

## Configuration
- `HFC_STATS_EN` defined:
  - `stall_cnt_o` increments on each stall cycle.
  - `fwd_cnt_o` increments by 1 or 2 per cycle, counting each nonzero select loaded.
  - Both counters saturate at all-ones and clear on reset.
- `HFC_STATS_EN` undefined: the ports and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold `rst_i`=0 mid-stream, then release. Required: selects 00, `pc_write_o`=1, no stall until new instructions enter.
- ALU chain `add r3,r1,r2` then `sub r4,r3,r5`. Required: `fwd_a_sel_o`=10 in the sub's EX cycle. With one unrelated instruction between them, `fwd_a_sel_o`=01.
- Double hazard: writes to r3 in both the mem-bound and wb-bound slots, consumer reads r3 in rt. Required: `fwd_b_sel_o`=10 (priority).
- Load-use `lw r8,0(r1)` then `add r9,r8,r8`:
  - Exactly one cycle with `pc_write_o`=0, `ifid_write_o`=0, `idex_bubble_o`=1.
  - Then both selects 01 in the add's EX cycle.
  - With stats enabled, `stall_cnt_o`=1 and `fwd_cnt_o`=2.
- Writes to r0 followed by a read of r0. Required: selects stay 00 and no stall, including for `lw r0`.
- Load-use stall coinciding with `ex_branch_taken_i`=1. Required: `ifid_flush_o`=1, `pc_write_o`=1, bubble inserted, and the next cycle shows no stall.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: load-use stall, taken-branch squash and EX operand
// forwarding for a 5-stage pipeline.
// Optional statistics counters are built only when HFC_STATS_EN is defined.
//
// Handshake: there is no valid/ready pair on this block. pc_write_o and
// ifid_write_o are enables that the pipeline obeys in the same cycle.
// idex_bubble_o and ifid_flush_o are same-cycle zeroing requests.
// When id_valid_i=1 and pc_write_o=0, the ID instruction is held and must be
// presented again on the next cycle.
module hazard_fwd_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              ex_branch_taken_i,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              idex_bubble_o,
  output logic              ifid_flush_o
`ifdef HFC_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  fwd_cnt_o
`endif
);

  // Forwarding selects are resolved when an instruction enters EX.
  // As a result, the EX entry does not keep its own source registers.
  // The write-back slot is also not kept, because nothing reads it after
  // that forwarding decision has been made.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } ex_entry_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } mem_entry_t;

  ex_entry_t  ex_q, ex_d;
  mem_entry_t mem_q;
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;

  logic stall_raw;
  logic stall_eff;
  logic bubble_in;
  logic ex_can_fwd;
  logic mem_can_fwd;

  // Load-use hazard: the load in EX produces a register that ID wants now.
  always_comb begin
    stall_raw = ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                ((ex_q.rd == id_rs_i) || (ex_q.rd == id_rt_i)) && id_valid_i;
    stall_eff = stall_raw && !ex_branch_taken_i;
    bubble_in = stall_raw || ex_branch_taken_i || !id_valid_i;
  end

  // Pipeline control outputs.
  // A taken branch overrides a stall so that the branch target gets fetched.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    idex_bubble_o = 1'b0;
    ifid_flush_o  = 1'b0;
    if (rst_i) begin
      if (ex_branch_taken_i) begin
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end else if (stall_raw) begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end
    end
  end

  // Next EX entry and its forwarding selects.
  // The current EX entry is bound for MEM next cycle; the current MEM entry
  // is bound for WB. A load cannot forward from the MEM-bound slot.
  always_comb begin
    ex_can_fwd  = ex_q.valid && ex_q.regwrite && !ex_q.memread && (ex_q.rd != '0);
    mem_can_fwd = mem_q.valid && mem_q.regwrite && (mem_q.rd != '0);

    ex_d.valid    = !bubble_in;
    ex_d.rd       = id_rd_i;
    ex_d.regwrite = id_regwrite_i;
    ex_d.memread  = id_memread_i;

    fwd_a_d = 2'b00;
    if (ex_can_fwd && (ex_q.rd == id_rs_i)) begin
      fwd_a_d = 2'b10;
    end else if (mem_can_fwd && (mem_q.rd == id_rs_i)) begin
      fwd_a_d = 2'b01;
    end

    fwd_b_d = 2'b00;
    if (ex_can_fwd && (ex_q.rd == id_rt_i)) begin
      fwd_b_d = 2'b10;
    end else if (mem_can_fwd && (mem_q.rd == id_rt_i)) begin
      fwd_b_d = 2'b01;
    end

    if (bubble_in) begin
      ex_d    = '0;
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
    end
  end

  // Shadow pipeline advance and registered selects.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel_o = fwd_a_q;
  assign fwd_b_sel_o = fwd_b_q;

`ifdef HFC_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [1:0]       fwd_inc;
  logic [CNT_W:0]   fwd_sum;

  // Saturating statistics.
  // A stall that is overridden by a taken branch is not counted.
  always_comb begin
    fwd_inc = {1'b0, (fwd_a_d != 2'b00)} + {1'b0, (fwd_b_d != 2'b00)};
    fwd_sum = {1'b0, fwd_cnt_q} + {{(CNT_W-1){1'b0}}, fwd_inc};
    fwd_cnt_d = fwd_sum[CNT_W] ? {CNT_W{1'b1}} : fwd_sum[CNT_W-1:0];
    stall_cnt_d = stall_cnt_q;
    if (stall_eff && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`else
  // Without statistics, the effective stall term has no consumer.
  logic unused_stall_eff;
  assign unused_stall_eff = stall_eff;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl.
// Each table row is one ID cycle. The row gives the inputs, the expected
// same-cycle control outputs, and the selects expected after the clock edge.
module tb_hazard_fwd_ctrl;

  logic       clk;
  logic       rst_i;
  logic       id_valid_i;
  logic [4:0] id_rs_i, id_rt_i, id_rd_i;
  logic       id_regwrite_i, id_memread_i, ex_branch_taken_i;
  logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
  logic       pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o;
`ifdef HFC_STATS_EN
  logic [15:0] stall_cnt_o, fwd_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .id_valid_i       (id_valid_i),
    .id_rs_i          (id_rs_i),
    .id_rt_i          (id_rt_i),
    .id_rd_i          (id_rd_i),
    .id_regwrite_i    (id_regwrite_i),
    .id_memread_i     (id_memread_i),
    .ex_branch_taken_i(ex_branch_taken_i),
    .fwd_a_sel_o      (fwd_a_sel_o),
    .fwd_b_sel_o      (fwd_b_sel_o),
    .pc_write_o       (pc_write_o),
    .ifid_write_o     (ifid_write_o),
    .idex_bubble_o    (idex_bubble_o),
    .ifid_flush_o     (ifid_flush_o)
`ifdef HFC_STATS_EN
    ,
    .stall_cnt_o      (stall_cnt_o),
    .fwd_cnt_o        (fwd_cnt_o)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, rd;
    logic       rw, mr, br;
    logic       pc, ifw, bub, fl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic v, input logic [4:0] rs, rt, rd,
                              input logic rw, mr, br, pc, ifw, bub, fl,
                              input logic [1:0] fa, fb);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.rd = rd;
    r.rw = rw; r.mr = mr; r.br = br;
    r.pc = pc; r.ifw = ifw; r.bub = bub; r.fl = fl;
    r.fa = fa; r.fb = fb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid_i        = t.v;
    id_rs_i           = t.rs;
    id_rt_i           = t.rt;
    id_rd_i           = t.rd;
    id_regwrite_i     = t.rw;
    id_memread_i      = t.mr;
    ex_branch_taken_i = t.br;
  endtask

  // Drive at the falling edge and check the control outputs in that cycle.
  // Then check the selects just after the rising edge.
  task automatic apply_vec(input string tag, input vec_t t);
    @(negedge clk);
    drive(t);
    #1;
    chk({tag, ".pc_write"},   {31'd0, pc_write_o},    {31'd0, t.pc});
    chk({tag, ".ifid_write"}, {31'd0, ifid_write_o},  {31'd0, t.ifw});
    chk({tag, ".bubble"},     {31'd0, idex_bubble_o}, {31'd0, t.bub});
    chk({tag, ".flush"},      {31'd0, ifid_flush_o},  {31'd0, t.fl});
    @(posedge clk);
    #1;
    chk({tag, ".fwd_a"}, {30'd0, fwd_a_sel_o}, {30'd0, t.fa});
    chk({tag, ".fwd_b"}, {30'd0, fwd_b_sel_o}, {30'd0, t.fb});
  endtask

  initial begin
    //              v  rs  rt  rd  rw mr br  pc ifw bub fl  fa     fb
    vecs[0]  = mk(1, 1,  2,  3,  1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00); // add r3,r1,r2
    vecs[1]  = mk(1, 3,  5,  4,  1, 0, 0,  1, 1, 0, 0, 2'b10, 2'b00); // sub r4,r3,r5
    vecs[2]  = mk(0, 0,  0,  0,  0, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00); // nop
    vecs[3]  = mk(1, 1,  2,  6,  1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00); // add r6,r1,r2
    vecs[4]  = mk(1, 1,  1,  7,  1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00); // or r7 (gap)
    vecs[5]  = mk(1, 6,  9, 10,  1, 0, 0,  1, 1, 0, 0, 2'b01, 2'b00); // and r10,r6,r9
    vecs[6]  = mk(1, 1,  2,  3,  1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00); // add r3 (wb-bound)
    vecs[7]  = mk(1, 4,  5,  3,  1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00); // add r3 (mem-bound)
    vecs[8]  = mk(1, 1,  3, 11,  1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b10); // sub r11,r1,r3
    vecs[9]  = mk(1, 1,  0,  8,  1, 1, 0,  1, 1, 0, 0, 2'b00, 2'b00); // lw r8,0(r1)
    vecs[10] = mk(1, 8,  8,  9,  1, 0, 0,  0, 0, 1, 0, 2'b00, 2'b00); // add r9 stalled
    vecs[11] = mk(1, 8,  8,  9,  1, 0, 0,  1, 1, 0, 0, 2'b01, 2'b01); // add r9 again
    vecs[12] = mk(1, 1,  2,  0,  1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00); // add r0,r1,r2
    vecs[13] = mk(1, 1,  0,  0,  1, 1, 0,  1, 1, 0, 0, 2'b00, 2'b00); // lw r0,0(r1)
    vecs[14] = mk(1, 0,  0, 12,  1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00); // add r12,r0,r0
    vecs[15] = mk(1, 0,  0, 13,  1, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00); // add r13,r0,r0
    vecs[16] = mk(1, 1,  0,  5,  1, 1, 0,  1, 1, 0, 0, 2'b00, 2'b00); // lw r5,0(r1)
    vecs[17] = mk(1, 5,  1,  6,  1, 0, 1,  1, 1, 1, 1, 2'b00, 2'b00); // use + branch
    vecs[18] = mk(1, 5,  2,  7,  1, 0, 0,  1, 1, 0, 0, 2'b01, 2'b00); // target reads r5

    // Reset state.
    rst_i = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    #12;
    chk("reset.pc_write",   {31'd0, pc_write_o},    32'd1);
    chk("reset.ifid_write", {31'd0, ifid_write_o},  32'd1);
    chk("reset.bubble",     {31'd0, idex_bubble_o}, 32'd0);
    chk("reset.flush",      {31'd0, ifid_flush_o},  32'd0);
    chk("reset.fwd_a",      {30'd0, fwd_a_sel_o},   32'd0);
    chk("reset.fwd_b",      {30'd0, fwd_b_sel_o},   32'd0);
`ifdef HFC_STATS_EN
    chk("reset.stall_cnt",  {16'd0, stall_cnt_o},   32'd0);
    chk("reset.fwd_cnt",    {16'd0, fwd_cnt_o},     32'd0);
`endif
    @(negedge clk);
    rst_i = 1'b1;

    // Main table.
    for (int i = 0; i < 19; i++) begin
      apply_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset asserted in the middle of a stall.
    // lw r8,0(r7) forwards r7 from the MEM-bound add r7, so fwd_a becomes 10.
    apply_vec("mid.lw", mk(1, 7, 0, 8, 1, 1, 0, 1, 1, 0, 0, 2'b10, 2'b00));
    @(negedge clk);
    drive(mk(1, 8, 8, 9, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    #1;
    chk("mid.stall_pc", {31'd0, pc_write_o}, 32'd0);
    #1;
    rst_i = 1'b0;
    ex_branch_taken_i = 1'b1;
    #1;
    chk("mid.rst_pc_write",   {31'd0, pc_write_o},    32'd1);
    chk("mid.rst_ifid_write", {31'd0, ifid_write_o},  32'd1);
    chk("mid.rst_bubble",     {31'd0, idex_bubble_o}, 32'd0);
    chk("mid.rst_flush",      {31'd0, ifid_flush_o},  32'd0);
    chk("mid.rst_fwd_a",      {30'd0, fwd_a_sel_o},   32'd0);
    chk("mid.rst_fwd_b",      {30'd0, fwd_b_sel_o},   32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    ex_branch_taken_i = 1'b0;
    #1;
    chk("post_rst.pc_write", {31'd0, pc_write_o},    32'd1);
    chk("post_rst.bubble",   {31'd0, idex_bubble_o}, 32'd0);

    // Idle cycles after reset, then a load-use pair on a fresh pipeline.
    apply_vec("idle0", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00));
    apply_vec("idle1", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00));
    apply_vec("st.lw",    mk(1, 1, 0, 8, 1, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00));
    apply_vec("st.stall", mk(1, 8, 8, 9, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00));
    apply_vec("st.add",   mk(1, 8, 8, 9, 1, 0, 0, 1, 1, 0, 0, 2'b01, 2'b01));
`ifdef HFC_STATS_EN
    chk("st.stall_cnt", {16'd0, stall_cnt_o}, 32'd1);
    chk("st.fwd_cnt",   {16'd0, fwd_cnt_o},   32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
